led_seq_scheduler: RTL and testbench

LED_SEQ_SCHEDULER -- requirements
Module: led_seq_scheduler

---
 rtl/led_seq_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_led_seq_scheduler.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/led_seq_scheduler.sv
// Ten-LED pattern sequencer (chase-up/down, bounce, fill) stepped every TICK_DIV clocks, with lap counting.
// All outputs registered; start takes effect one cycle later; no backpressure, pause freezes position and prescaler.
module led_seq_scheduler #(
    parameter int unsigned TICK_DIV = 16384
) (
    input  logic       clk_50M,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic [1:0] mode,
    input  logic [3:0] laps,
    output logic [9:0] led,
    output logic       busy,
    output logic       step,
    output logic       done
);

    localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        M_UP     = 2'b00,
        M_DOWN   = 2'b01,
        M_BOUNCE = 2'b10,
        M_FILL   = 2'b11
    } mode_t;

    state_t        state_q, state_d;
    mode_t         mode_q, mode_d;
    logic [3:0]    laps_q, laps_d;
    logic [3:0]    pos_q, pos_d;
    logic          dir_down_q, dir_down_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    lap_q, lap_d;
    logic [9:0]    led_d;
    logic          busy_d, step_d, done_d;

    logic [3:0]    nxt_pos;
    logic          nxt_dir_down;
    logic          lap_end;
    logic          last_lap;

    function automatic logic [9:0] pattern(input mode_t m, input logic [3:0] p);
        logic [10:0] fill;
        fill = (11'd1 << (p + 4'd1)) - 11'd1;
        if (m == M_FILL) begin
            return fill[9:0];
        end
        return 10'd1 << p;
    endfunction

    always_ff @(posedge clk_50M or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            mode_q     <= M_UP;
            laps_q     <= 4'd0;
            pos_q      <= 4'd0;
            dir_down_q <= 1'b0;
            presc_q    <= '0;
            lap_q      <= 4'd0;
            led        <= 10'd0;
            busy       <= 1'b0;
            step       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            laps_q     <= laps_d;
            pos_q      <= pos_d;
            dir_down_q <= dir_down_d;
            presc_q    <= presc_d;
            lap_q      <= lap_d;
            led        <= led_d;
            busy       <= busy_d;
            step       <= step_d;
            done       <= done_d;
        end
    end

    always_comb begin
        nxt_pos      = pos_q;
        nxt_dir_down = dir_down_q;
        lap_end      = 1'b0;
        state_d      = state_q;
        mode_d       = mode_q;
        laps_d       = laps_q;
        pos_d        = pos_q;
        dir_down_d   = dir_down_q;
        presc_d      = presc_q;
        lap_d        = lap_q;
        led_d        = led;
        step_d       = 1'b0;
        done_d       = 1'b0;

        // Candidate position for the next tick, and whether that tick closes a lap.
        case (mode_q)
            M_DOWN: begin
                if (pos_q == 4'd0) begin
                    nxt_pos = 4'd9;
                    lap_end = 1'b1;
                end else begin
                    nxt_pos = pos_q - 4'd1;
                end
            end
            M_BOUNCE: begin
                if (!dir_down_q) begin
                    if (pos_q >= 4'd9) begin
                        nxt_pos      = 4'd8;
                        nxt_dir_down = 1'b1;
                    end else begin
                        nxt_pos = pos_q + 4'd1;
                    end
                end else if (pos_q <= 4'd1) begin
                    nxt_pos      = 4'd0;
                    nxt_dir_down = 1'b0;
                    lap_end      = 1'b1;
                end else begin
                    nxt_pos = pos_q - 4'd1;
                end
            end
            default: begin
                if (pos_q >= 4'd9) begin
                    nxt_pos = 4'd0;
                    lap_end = 1'b1;
                end else begin
                    nxt_pos = pos_q + 4'd1;
                end
            end
        endcase

        last_lap = lap_end && (laps_q != 4'd0) && ((lap_q + 4'd1) == laps_q);

        case (state_q)
            S_IDLE: begin
                led_d   = 10'd0;
                presc_d = '0;
                if (start && !stop) begin
                    state_d    = S_RUN;
                    mode_d     = mode_t'(mode);
                    laps_d     = laps;
                    pos_d      = (mode_t'(mode) == M_DOWN) ? 4'd9 : 4'd0;
                    dir_down_d = 1'b0;
                    lap_d      = 4'd0;
                    led_d      = pattern(mode_t'(mode), pos_d);
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
                    led_d   = 10'd0;
                    presc_d = '0;
                end else if (pause) begin
                    state_d = S_PAUSE;
                end else if (presc_q == PS_LAST) begin
                    presc_d = '0;
                    if (last_lap) begin
                        state_d = S_IDLE;
                        led_d   = 10'd0;
                        lap_d   = lap_q + 4'd1;
                        done_d  = 1'b1;
                    end else begin
                        pos_d      = nxt_pos;
                        dir_down_d = nxt_dir_down;
                        led_d      = pattern(mode_q, nxt_pos);
                        step_d     = 1'b1;
                        if (lap_end && (lap_q != 4'd15)) begin
                            lap_d = lap_q + 4'd1;
                        end
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            S_PAUSE: begin
                if (stop) begin
                    state_d = S_IDLE;
                    led_d   = 10'd0;
                    presc_d = '0;
                end else if (!pause) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
                led_d   = 10'd0;
                presc_d = '0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

endmodule

// File: tb/tb_led_seq_scheduler.sv
// Directed bench for led_seq_scheduler at TICK_DIV=4: vector table plus multi-cycle pattern sequences.
module tb_led_seq_scheduler;

    logic       clk_50M;
    logic       reset;
    logic       start;
    logic       stop;
    logic       pause;
    logic [1:0] mode;
    logic [3:0] laps;
    logic [9:0] led;
    logic       busy;
    logic       step;
    logic       done;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic       start;
        logic       stop;
        logic       pause;
        logic [1:0] mode;
        logic [3:0] laps;
        logic [9:0] led;
        logic       busy;
        logic       step;
        logic       done;
    } vec_t;

    vec_t tbl [13];

    led_seq_scheduler #(.TICK_DIV(4)) dut (
        .clk_50M (clk_50M),
        .reset   (reset),
        .start   (start),
        .stop    (stop),
        .pause   (pause),
        .mode    (mode),
        .laps    (laps),
        .led     (led),
        .busy    (busy),
        .step    (step),
        .done    (done)
    );

    initial clk_50M = 1'b0;
    always #5 clk_50M = ~clk_50M;

    task automatic chk(input string name, input logic [9:0] el, input logic eb,
                       input logic es, input logic ed);
        n_vec++;
        if ({led, busy, step, done} !== {el, eb, es, ed}) begin
            n_bad++;
            $display("FAIL %s: got led=%h busy=%b step=%b done=%b, want led=%h busy=%b step=%b done=%b",
                     name, led, busy, step, done, el, eb, es, ed);
        end
    endtask

    // Drive inputs, take one rising edge, sample 1 time unit later.
    task automatic cyc(input logic s, input logic sp, input logic p,
                       input logic [1:0] m, input logic [3:0] l);
        start = s;
        stop  = sp;
        pause = p;
        mode  = m;
        laps  = l;
        @(posedge clk_50M);
        #1;
    endtask

    // LED image after i ticks from the start of a sequence.
    function automatic logic [9:0] exp_pat(input logic [1:0] m, input int i);
        int p;
        int v;
        case (m)
            2'b00: v = 1 << (i % 10);
            2'b01: v = 1 << (9 - (i % 10));
            2'b10: begin
                p = i % 18;
                if (p > 9) p = 18 - p;
                v = 1 << p;
            end
            default: v = (1 << ((i % 10) + 1)) - 1;
        endcase
        return v[9:0];
    endfunction

    // Start a sequence and follow it tick by tick; mode/laps are scrambled while busy.
    task automatic run_seq(input string name, input logic [1:0] m, input logic [3:0] l,
                           input int n_ticks, input logic final_start);
        cyc(1'b1, 1'b0, 1'b0, m, l);
        chk($sformatf("%s_start", name), exp_pat(m, 0), 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= n_ticks; i++) begin
            for (int c = 0; c < 3; c++) begin
                cyc(1'b0, 1'b0, 1'b0, ~m, ~l);
                chk($sformatf("%s_hold%0d", name, i), exp_pat(m, i - 1), 1'b1, 1'b0, 1'b0);
            end
            cyc(final_start && (i == n_ticks), 1'b0, 1'b0, ~m, ~l);
            if (i < n_ticks || l == 4'd0)
                chk($sformatf("%s_tick%0d", name, i), exp_pat(m, i), 1'b1, 1'b1, 1'b0);
            else
                chk($sformatf("%s_done", name), 10'd0, 1'b0, 1'b0, 1'b1);
        end
        if (l != 4'd0) begin
            cyc(1'b0, 1'b0, 1'b0, m, l);
            chk($sformatf("%s_idle", name), 10'd0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        pause = 1'b0;
        mode  = 2'b00;
        laps  = 4'd0;

        //            start stop pause mode  laps   led      busy step done
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 2'b00, 4'd0, 10'h000, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b0, 2'b00, 4'd1, 10'h000, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 2'b01, 4'd0, 10'h200, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 2'b00, 4'd1, 10'h200, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 2'b00, 4'd1, 10'h200, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 2'b00, 4'd1, 10'h200, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 2'b00, 4'd1, 10'h100, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 2'b00, 4'd1, 10'h000, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 2'b00, 4'd1, 10'h000, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 2'b00, 4'd1, 10'h001, 1'b1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 2'b00, 4'd1, 10'h001, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b1, 2'b00, 4'd1, 10'h000, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 2'b00, 4'd1, 10'h000, 1'b0, 1'b0, 1'b0};

        #12;
        chk("reset_state", 10'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        @(posedge clk_50M);
        #1;

        for (int i = 0; i < 13; i++) begin
            cyc(tbl[i].start, tbl[i].stop, tbl[i].pause, tbl[i].mode, tbl[i].laps);
            chk($sformatf("vec%0d", i), tbl[i].led, tbl[i].busy, tbl[i].step, tbl[i].done);
        end

        // Chase-up one lap; a start arrives together with the final tick and is dropped.
        run_seq("up1", 2'b00, 4'd1, 10, 1'b1);
        run_seq("bounce1", 2'b10, 4'd1, 18, 1'b0);
        run_seq("fill2", 2'b11, 4'd2, 20, 1'b0);

        // Pause mid-count, then pause exactly in a tick cycle.
        cyc(1'b1, 1'b0, 1'b0, 2'b00, 4'd0);
        chk("pz_start", 10'h001, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 2'b00, 4'd0);
            chk("pz_pre", 10'h001, 1'b1, 1'b0, 1'b0);
        end
        for (int k = 0; k < 10; k++) begin
            cyc(1'b0, 1'b0, 1'b1, 2'b00, 4'd0);
            chk($sformatf("pz_frozen%0d", k), 10'h001, 1'b1, 1'b0, 1'b0);
        end
        cyc(1'b0, 1'b0, 1'b0, 2'b00, 4'd0);
        chk("pz_resume", 10'h001, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 2'b00, 4'd0);
        chk("pz_count", 10'h001, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 2'b00, 4'd0);
        chk("pz_step", 10'h002, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b0, 1'b0, 2'b00, 4'd0);
            chk("pz_run", 10'h002, 1'b1, 1'b0, 1'b0);
        end
        cyc(1'b0, 1'b0, 1'b1, 2'b00, 4'd0);
        chk("pz_tick_suppressed", 10'h002, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 2'b00, 4'd0);
        chk("pz_resume2", 10'h002, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 2'b00, 4'd0);
        chk("pz_step2", 10'h004, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 2'b00, 4'd0);
        chk("pz_stop", 10'h000, 1'b0, 1'b0, 1'b0);

        // Free-running chase-down, then stop and start together.
        run_seq("down_free", 2'b01, 4'd0, 35, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 2'b01, 4'd0);
        chk("stop_start", 10'h000, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 2'b01, 4'd0);
        chk("stop_start_idle", 10'h000, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset between edges while running.
        cyc(1'b1, 1'b0, 1'b0, 2'b00, 4'd0);
        chk("ar_start", 10'h001, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, 1'b0, 2'b00, 4'd0);
        chk("ar_running", 10'h002, 1'b1, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("ar_async_clear", 10'h000, 1'b0, 1'b0, 1'b0);
        #2 reset = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 2'b11, 4'd1);
        chk("ar_restart", 10'h001, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 2'b11, 4'd1);
        chk("ar_stop", 10'h000, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
